// File: rtl/instr_encoder.sv
// Program-image builder: encodes instruction requests into 32-bit ARM words and
// writes them into instruction memory, followed by a terminator word on finish.
module instr_encoder #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] TERM_WORD = 32'hE1A00000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic              req_imm_sel,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rm,
  input  logic [11:0]       req_imm,
  input  logic [4:0]        req_shamt,
  input  logic [1:0]        req_sh,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_TERM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last slot (all ones) is held back for the terminator word.
  localparam logic [ADDR_W-1:0] LAST_SLOT = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                accept;
  logic [31:0]         enc_word;

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic        imm_sel,
    input logic [3:0]  rd,
    input logic [3:0]  rn,
    input logic [3:0]  rm,
    input logic [11:0] imm,
    input logic [4:0]  shamt,
    input logic [1:0]  sh
  );
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;
    logic [3:0]  rd_f;
    logic [3:0]  rn_f;
    logic [11:0] src2;
    cmd = 4'b0000;
    unique case (kind)
      3'd0:    cmd = 4'b0000;
      3'd1:    cmd = 4'b0100;
      3'd2:    cmd = 4'b0010;
      3'd3:    cmd = 4'b1100;
      3'd4:    cmd = 4'b1010;
      3'd5:    cmd = 4'b1101;
      default: cmd = 4'b0000;
    endcase
    if (kind[2:1] == 2'b11) begin
      // Memory transfer: immediate offset, pre-index, add, word, no writeback.
      op    = 2'b01;
      funct = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ~kind[0]};
      rd_f  = rd;
      rn_f  = rn;
      src2  = imm;
    end else begin
      op    = 2'b00;
      funct = {imm_sel, cmd, (kind == 3'd4)};
      rd_f  = (kind == 3'd4) ? 4'd0 : rd;
      rn_f  = (kind == 3'd5) ? 4'd0 : rn;
      src2  = imm_sel ? imm : {shamt, sh, 1'b0, rm};
    end
    return {4'hE, op, funct, rn_f, rd_f, src2};
  endfunction

  assign req_ready = (state_q == S_LOAD) && (ptr_q != LAST_SLOT);
  assign accept    = req_valid && req_ready;
  assign enc_word  = encode(req_kind, req_imm_sel, req_rd, req_rn, req_rm,
                            req_imm, req_shamt, req_sh);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    if (start) begin
      state_d = S_LOAD;
      ptr_d   = '0;
      len_d   = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (accept) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + ADDR_W'(1);
          end
          if (finish) state_d = S_TERM;
        end
        S_TERM: begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = TERM_WORD;
          len_d   = {1'b0, ptr_q} + (ADDR_W + 1)'(1);
          state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_TERM);
  assign done       = (state_q == S_DONE);
  assign prog_len   = len_q;

endmodule
